// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: round-robin frequency monitor for up to 16 clocks.
// Each measured clock is prescaled in its own domain to a slow toggle. The
// toggle is synchronised into clk and its transitions are counted over a
// 1 ms gate. Defining FREQ_MON_MINMAX_EN adds per-channel min/max tracking.
//
// state  | meaning
// IDLE   | no channel enabled, waiting
// SETTLE | new channel selected, synchroniser flushing, edges ignored
// GATE   | counting toggle edges of the selected channel
// LATCH  | publish result, advance to the next enabled channel
module clk_freq_monitor #(
  parameter int N_CH          = 7,
  parameter int REF_FREQ_HZ   = 200000000,
  parameter int PRESCALE_LOG2 = 3,
  parameter int SETTLE_CYCLES = 16,
  parameter int CNT_W         = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_CH-1:0]      meas_clk,
  input  logic [N_CH-1:0]      ch_enable,
  output logic [32*N_CH-1:0]   freq_khz,
  output logic [N_CH-1:0]      freq_valid,
  output logic [N_CH-1:0]      freq_stuck,
  output logic                 upd_strobe,
`ifdef FREQ_MON_MINMAX_EN
  output logic [32*N_CH-1:0]   freq_min_khz,
  output logic [32*N_CH-1:0]   freq_max_khz,
`endif
  output logic [3:0]           upd_ch
);

  localparam int GATE_CYCLES = REF_FREQ_HZ / 1000;
  localparam int TMR_MAX     = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
  localparam int TMR_W       = $clog2(TMR_MAX + 1);
  localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_GATE, S_LATCH} state_t;

  // Lowest set bit of mask at or above start, wrapping; bit 4 flags found.
  function automatic logic [4:0] pick(input logic [N_CH-1:0] mask, input int start);
    logic [4:0] r;
    r = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      int j;
      logic [N_CH-1:0] sh;
      j = start + k;
      if (j >= N_CH) j = j - N_CH;
      sh = mask >> j;
      if (sh[0]) r = {1'b1, 4'(j)};
    end
    return r;
  endfunction

  logic [N_CH-1:0] tog;

  for (genvar g = 0; g < N_CH; g++) begin : g_meas
    logic [PRESCALE_LOG2-1:0] pre_q, pre_d;
    logic                     tog_q, tog_d;

    // Prescaler wraps every 2^PRESCALE_LOG2 cycles and flips the toggle.
    always_comb begin
      pre_d = pre_q + PRESCALE_LOG2'(1);
      tog_d = (&pre_q) ? ~tog_q : tog_q;
    end

    // Measured-domain registers, cleared by the shared reset.
    always_ff @(posedge meas_clk[g] or posedge reset) begin
      if (reset) begin
        pre_q <= '0;
        tog_q <= 1'b0;
      end else begin
        pre_q <= pre_d;
        tog_q <= tog_d;
      end
    end

    assign tog[g] = tog_q;
  end

  logic [N_CH-1:0] sync1_q, sync1_d, sync2_q, sync2_d, sync3_q, sync3_d;
  logic [N_CH-1:0] edge_det;

  // Two-stage synchroniser followed by the edge-detect stage.
  always_comb begin
    sync1_d  = tog;
    sync2_d  = sync1_q;
    sync3_d  = sync2_q;
    edge_det = sync2_q ^ sync3_q;
  end

  // Synchroniser registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      sync3_q <= sync3_d;
    end
  end

  state_t                   state_q, state_d;
  logic [3:0]               ch_q, ch_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [N_CH-1:0][31:0]    freq_q, freq_d;
  logic [N_CH-1:0]          valid_q, valid_d, stuck_q, stuck_d;
  logic                     upd_strobe_q, upd_strobe_d;
  logic [3:0]               upd_ch_q, upd_ch_d;
`ifdef FREQ_MON_MINMAX_EN
  logic [N_CH-1:0][31:0]    min_q, min_d, max_q, max_d;
  logic [N_CH-1:0]          first_q, first_d;
`endif

  logic [N_CH-1:0] en_sh, edge_sh;
  logic [4:0]      pick_cur, pick_nxt;
  logic [31:0]     meas_khz;
  logic            do_adv;

  // Sequencer next-state and result write-back.
  always_comb begin
    state_d      = state_q;
    ch_d         = ch_q;
    tmr_d        = tmr_q;
    cnt_d        = cnt_q;
    freq_d       = freq_q;
    valid_d      = valid_q & ch_enable;
    stuck_d      = stuck_q & ch_enable;
    upd_strobe_d = 1'b0;
    upd_ch_d     = upd_ch_q;
    do_adv       = 1'b0;
    en_sh        = ch_enable >> ch_q;
    edge_sh      = edge_det >> ch_q;
    pick_cur     = pick(ch_enable, int'(ch_q));
    pick_nxt     = pick(ch_enable, int'(ch_q) + 1);
    meas_khz     = 32'(cnt_q) << PRESCALE_LOG2;
`ifdef FREQ_MON_MINMAX_EN
    min_d        = min_q;
    max_d        = max_q;
    first_d      = first_q | ~ch_enable;
`endif

    case (state_q)
      S_IDLE: begin
        if (pick_cur[4]) begin
          ch_d    = pick_cur[3:0];
          tmr_d   = SETTLE_LOAD;
          cnt_d   = '0;
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (!en_sh[0]) begin
          do_adv = 1'b1;
        end else if (tmr_q == '0) begin
          tmr_d   = GATE_LOAD;
          cnt_d   = '0;
          state_d = S_GATE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_GATE: begin
        if (!en_sh[0]) begin
          do_adv = 1'b1;
        end else begin
          if (edge_sh[0] && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
          if (tmr_q == '0) state_d = S_LATCH;
          else tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_LATCH: begin
        if (en_sh[0]) begin
          for (int i = 0; i < N_CH; i++) begin
            if (ch_q == 4'(i)) begin
              freq_d[i]  = meas_khz;
              valid_d[i] = 1'b1;
              stuck_d[i] = (cnt_q == '0);
`ifdef FREQ_MON_MINMAX_EN
              if (cnt_q != '0) begin
                first_d[i] = 1'b0;
                if (first_q[i]) begin
                  min_d[i] = meas_khz;
                  max_d[i] = meas_khz;
                end else begin
                  if (meas_khz < min_q[i]) min_d[i] = meas_khz;
                  if (meas_khz > max_q[i]) max_d[i] = meas_khz;
                end
              end
`endif
            end
          end
          upd_strobe_d = 1'b1;
          upd_ch_d     = ch_q;
        end
        do_adv = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort or completion both move on to the next enabled channel.
    if (do_adv) begin
      cnt_d = '0;
      if (pick_nxt[4]) begin
        ch_d    = pick_nxt[3:0];
        tmr_d   = SETTLE_LOAD;
        state_d = S_SETTLE;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  // Sequencer and result registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ch_q         <= '0;
      tmr_q        <= '0;
      cnt_q        <= '0;
      freq_q       <= '0;
      valid_q      <= '0;
      stuck_q      <= '0;
      upd_strobe_q <= 1'b0;
      upd_ch_q     <= '0;
`ifdef FREQ_MON_MINMAX_EN
      min_q        <= '1;
      max_q        <= '0;
      first_q      <= '1;
`endif
    end else begin
      state_q      <= state_d;
      ch_q         <= ch_d;
      tmr_q        <= tmr_d;
      cnt_q        <= cnt_d;
      freq_q       <= freq_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      upd_strobe_q <= upd_strobe_d;
      upd_ch_q     <= upd_ch_d;
`ifdef FREQ_MON_MINMAX_EN
      min_q        <= min_d;
      max_q        <= max_d;
      first_q      <= first_d;
`endif
    end
  end

  assign freq_khz   = freq_q;
  assign freq_valid = valid_q;
  assign freq_stuck = stuck_q;
  assign upd_strobe = upd_strobe_q;
  assign upd_ch     = upd_ch_q;
`ifdef FREQ_MON_MINMAX_EN
  assign freq_min_khz = min_q;
  assign freq_max_khz = max_q;
`endif

endmodule
